lc3b_pipe_ctrl: RTL and testbench

//  Parametrised pipeline-buffer chain with valid/stall/flush control, replacing the hard-wired

---
 rtl/lc3b_pipe_ctrl.sv | 115 +++++++++++
 tb/tb_lc3b_pipe_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_pipe_ctrl.sv
// Pipeline-buffer chain with global freeze, load-use bubble insertion, branch squash
// (deferred while frozen) and saturating stall/flush event counters.
module lc3b_pipe_ctrl #(
  parameter int STAGES      = 4,
  parameter int DATA_W      = 64,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     imem_wait,
  input  logic                     dmem_wait,
  input  logic                     hazard,
  input  logic                     flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     stall,
  output logic                     flush_pend,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         flush_count
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              fl_eff, hz_eff;

  always_comb begin
    stall    = imem_wait | dmem_wait;
    fl_eff   = (flush | flush_pend_q) & ~stall;
    hz_eff   = hazard & ~stall & ~fl_eff;
    in_ready = ~stall & ~hz_eff;
  end

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    flush_pend_d = flush_pend_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stall) begin
      // Frozen: a redirect seen now is remembered and applied once the wait ends.
      flush_pend_d = flush_pend_q | flush;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      flush_pend_d = 1'b0;
      for (int i = STAGES - 1; i >= 1; i--) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      if (fl_eff) begin
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
          valid_d[i] = 1'b0;
          data_d[i]  = '0;
        end
        if (flush_cnt_q != {CNT_W{1'b1}}) begin
          flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          flush_cnt_d = flush_cnt_q;
        end
      end else if (hz_eff) begin
        valid_d[0] = valid_q[0];
        data_d[0]  = data_q[0];
        valid_d[1] = 1'b0;
        data_d[1]  = '0;
      end else begin
        // Invalid entries carry zero so downstream decode sees a NOP.
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  assign stage_valid = valid_q;
  assign flush_pend  = flush_pend_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_lc3b_pipe_ctrl.sv
// Directed bench: stimulus pushes surviving payloads into a queue; a monitor pops them as they
// leave the oldest buffer. A second instance with CNT_W=2 checks counter saturation.
module tb_lc3b_pipe_ctrl;
  localparam int S = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, imem_wait, dmem_wait, hazard, flush;
  logic [W-1:0] in_data;
  logic in_ready, stall, flush_pend;
  logic [S-1:0] stage_valid;
  logic [S*W-1:0] stage_data;
  logic [15:0] stall_count, flush_count;
  logic in_ready2, stall2, flush_pend2;
  logic [S-1:0] stage_valid2;
  logic [S*W-1:0] stage_data2;
  logic [1:0] stall_count2, flush_count2;

  lc3b_pipe_ctrl u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait), .hazard(hazard), .flush(flush),
    .stage_valid(stage_valid), .stage_data(stage_data), .stall(stall), .flush_pend(flush_pend),
    .stall_count(stall_count), .flush_count(flush_count));

  lc3b_pipe_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait), .hazard(hazard), .flush(flush),
    .stage_valid(stage_valid2), .stage_data(stage_data2), .stall(stall2), .flush_pend(flush_pend2),
    .stall_count(stall_count2), .flush_count(flush_count2));

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q [$];
  bit last_adv = 1'b0;

  function automatic logic [W-1:0] sd(input int i);
    return stage_data[i*W +: W];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [63:0] d, input logic im, input logic dm,
                        input logic hz, input logic fl);
    in_valid = v; in_data = d; imem_wait = im; dmem_wait = dm; hazard = hz; flush = fl;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [63:0] d);
    set_in(v, d, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain();
    repeat (4) cyc(1'b0, 64'h0);
  endtask

  // Record whether the last edge moved the pipe, from the bench's own inputs.
  always @(posedge clk) last_adv = !(imem_wait | dmem_wait) && !reset;

  // Scoreboard monitor: each fresh valid payload at the oldest buffer is popped and compared.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && last_adv && stage_valid[S-1]) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL scoreboard: got unexpected %0h expected nothing", sd(S-1));
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", sd(S-1), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 64'hAA;
    imem_wait = 1'b0; dmem_wait = 1'b0; hazard = 1'b0; flush = 1'b0;
    tick(); tick();
    // T1 reset
    chk("rst_valid", 64'(stage_valid), 64'h0);
    for (int i = 0; i < S; i++) chk("rst_data", sd(i), 64'h0);
    chk("rst_pend", 64'(flush_pend), 64'h0);
    chk("rst_scnt", 64'(stall_count), 64'h0);
    chk("rst_fcnt", 64'(flush_count), 64'h0);
    reset = 1'b0;

    // T2 stream
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(64'(k));
      cyc(1'b1, 64'(k));
      if (k == 4) begin
        chk("t2_valid3", 64'(stage_valid[3]), 64'h1);
        chk("t2_buf3", sd(3), 64'h1);
        chk("t2_buf0", sd(0), 64'h4);
      end
    end
    drain();

    // T3 stall mid-stream
    for (int k = 10; k <= 13; k++) begin
      exp_q.push_back(64'(k));
      cyc(1'b1, 64'(k));
    end
    for (int j = 0; j < 3; j++) begin
      set_in(1'b1, 64'h99, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t3_ready", 64'(in_ready), 64'h0);
      chk("t3_stall", 64'(stall), 64'h1);
      tick();
    end
    chk("t3_valid", 64'(stage_valid), 64'hF);
    chk("t3_buf0", sd(0), 64'd13);
    chk("t3_buf3", sd(3), 64'd10);
    chk("t3_scnt", 64'(stall_count), 64'd3);
    chk("t3_scnt2", 64'(stall_count2), 64'd3);
    exp_q.push_back(64'd14); cyc(1'b1, 64'd14);
    exp_q.push_back(64'd15); cyc(1'b1, 64'd15);
    drain();
    chk("t3_drained", 64'(stage_valid), 64'h0);

    // T4 load-use hazard
    exp_q.push_back(64'd20); cyc(1'b1, 64'd20);
    exp_q.push_back(64'd21); cyc(1'b1, 64'd21);
    exp_q.push_back(64'd7);  cyc(1'b1, 64'd7);
    set_in(1'b1, 64'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_ready", 64'(in_ready), 64'h0);
    tick();
    chk("t4_buf0", sd(0), 64'd7);
    chk("t4_valid", 64'(stage_valid), 64'b1101);
    chk("t4_buf1", sd(1), 64'h0);
    chk("t4_buf2", sd(2), 64'd21);
    chk("t4_buf3", sd(3), 64'd20);
    exp_q.push_back(64'd8); cyc(1'b1, 64'd8);
    drain();

    // T5 flush with simultaneous hazard
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) exp_q.push_back(64'(k));
      cyc(1'b1, 64'(k));
    end
    set_in(1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_ready", 64'(in_ready), 64'h1);
    tick();
    chk("t5_valid", 64'(stage_valid), 64'b1100);
    chk("t5_buf0", sd(0), 64'h0);
    chk("t5_buf1", sd(1), 64'h0);
    chk("t5_buf2", sd(2), 64'd3);
    chk("t5_buf3", sd(3), 64'd2);
    chk("t5_fcnt", 64'(flush_count), 64'd1);
    drain();

    // T6 deferred, merged flush under imem_wait
    exp_q.push_back(64'd30); cyc(1'b1, 64'd30);
    exp_q.push_back(64'd31); cyc(1'b1, 64'd31);
    cyc(1'b1, 64'd32);
    set_in(1'b1, 64'h66, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_stall", 64'(stall), 64'h1);
    tick();
    chk("t6_pend", 64'(flush_pend), 64'h1);
    chk("t6_frozen", 64'(stage_valid), 64'b0111);
    chk("t6_buf0", sd(0), 64'd32);
    set_in(1'b1, 64'h66, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 64'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 64'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_pend_hold", 64'(flush_pend), 64'h1);
    tick();
    chk("t6_valid", 64'(stage_valid), 64'b1100);
    chk("t6_buf2", sd(2), 64'd31);
    chk("t6_buf3", sd(3), 64'd30);
    chk("t6_pend_clr", 64'(flush_pend), 64'h0);
    chk("t6_fcnt", 64'(flush_count), 64'd2);
    chk("t6_scnt", 64'(stall_count), 64'd6);
    chk("t6_scnt2_sat", 64'(stall_count2), 64'd3);
    drain();

    // Reset while stalled with a flush pending
    cyc(1'b1, 64'd40); cyc(1'b1, 64'd41);
    set_in(1'b1, 64'd42, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("t7_pend", 64'(flush_pend), 64'h1);
    reset = 1'b1;
    set_in(1'b1, 64'd43, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    chk("t7_valid", 64'(stage_valid), 64'h0);
    for (int i = 0; i < S; i++) chk("t7_data", sd(i), 64'h0);
    chk("t7_pend_clr", 64'(flush_pend), 64'h0);
    chk("t7_scnt", 64'(stall_count), 64'h0);
    chk("t7_fcnt", 64'(flush_count), 64'h0);
    cyc(1'b0, 64'h0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
